// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes main/sub countdown times and the
// controller state onto an 8-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame (idx 7->0 wrap) so a frame never tears.
// Optional macro LEADING_ZERO_BLANK_EN: blank a zero tens digit instead of "0".
module seg_scan_driver #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [6:0] main_rest_time,
    input  logic [6:0] sub_rest_time,
    input  logic [3:0] control_state,
    input  logic       disp_en,
    output logic [7:0] SIG_C,
    output logic [7:0] AN,
    output logic       frame_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       main_q, main_d;
    logic [6:0]       sub_q, sub_d;
    logic [3:0]       state_q, state_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             tick_q, tick_d;

    logic             div_term;
    logic             frame_wrap;
    logic [7:0]       slot_seg;

    // Hex digit to active-low segment code (dp off).
    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Tens digit of a 0..99 value; out-of-range values show a dash.
    function automatic logic [7:0] tens_seg(input logic [6:0] v);
        logic [3:0] t;
        logic [7:0] s;
        t = 4'(v / 7'd10);
        if (v > 7'd99) begin
            s = SEG_DASH;
        end else begin
            s = hex_seg(t);
`ifdef LEADING_ZERO_BLANK_EN
            if (t == 4'd0) begin
                s = SEG_BLANK;
            end
`endif
        end
        return s;
    endfunction

    // Ones digit of a 0..99 value; out-of-range values show a dash.
    function automatic logic [7:0] ones_seg(input logic [6:0] v);
        logic [7:0] s;
        if (v > 7'd99) begin
            s = SEG_DASH;
        end else begin
            s = hex_seg(4'(v % 7'd10));
        end
        return s;
    endfunction

    // Slot divider, digit index and per-frame input snapshot.
    always_comb begin
        div_term   = (div_q == DIV_LAST);
        frame_wrap = div_term && (idx_q == 3'd7);
        div_d      = div_term ? '0 : div_q + DIV_W'(1);
        idx_d      = div_term ? idx_q + 3'd1 : idx_q;
        main_d     = main_q;
        sub_d      = sub_q;
        state_d    = state_q;
        tick_d     = frame_wrap;
        if (frame_wrap) begin
            main_d  = main_rest_time;
            sub_d   = sub_rest_time;
            state_d = control_state;
        end
    end

    // Segment pattern for the slot that will be active after this edge.
    always_comb begin
        slot_seg = SEG_BLANK;
        case (idx_d)
            3'd0: slot_seg = tens_seg(main_d);
            3'd1: slot_seg = ones_seg(main_d);
            3'd2: slot_seg = tens_seg(sub_d);
            3'd3: slot_seg = ones_seg(sub_d);
            3'd4: slot_seg = hex_seg(state_d);
            default: slot_seg = SEG_BLANK;
        endcase
    end

    // Anode/segment drive; dark in div==0 so the digit change never ghosts.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        if (disp_en && (div_d != '0)) begin
            an_d  = ~(8'h80 >> idx_d);
            seg_d = slot_seg;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            div_q   <= '0;
            idx_q   <= 3'd0;
            main_q  <= 7'd0;
            sub_q   <= 7'd0;
            state_q <= 4'd0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            main_q  <= main_d;
            sub_q   <= sub_d;
            state_q <= state_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign SIG_C      = seg_q;
    assign AN         = an_q;
    assign frame_tick = tick_q;

endmodule
